// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Program loader for the instruction memory. It takes a byte stream (for
// example from a UART receiver), assembles big-endian 16-bit instruction
// words and writes them to consecutive instruction addresses. The CPU is
// held in reset through cpu_hold until a complete, valid image is in memory.
//
// Stream format: LEN_HI, LEN_LO (word count N), then N words with the high
// byte first. With checksum checking built in, a trailing checksum word
// follows, also high byte first.
//
// Build option:
//   LOADER_CHECKSUM_EN  defined   : keep a running 16-bit sum of the written
//                                   words and compare it with the trailing
//                                   checksum word before declaring DONE.
//                       undefined : no checksum word; the last write goes
//                                   straight to DONE.
//
// Parameters:
//   BASE_ADDR  byte address of the first instruction (must be even)
//   MAX_WORDS  largest accepted image length in words
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle pulse, starts a load from IDLE, DONE or ERROR
//   in_valid   byte on in_data is valid
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction-memory write strobe, one cycle per word
//   mem_addr   byte address of the write
//   mem_wdata  instruction word being written
//   cpu_hold   keeps the CPU in reset while high
//   busy       a load is in progress
//   done       image loaded successfully (level)
//   error      load failed (level)
//   word_cnt   words written in the current or last load
// ---------------------------------------------------------------------------
module inst_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM_HI,
        S_CSUM_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] word_cnt_q, word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] len_rx;

    assign xfer   = in_valid && in_ready;
    assign len_rx = {hi_q, in_data};

    // Outputs are pure decodes of the registered state, so in_ready rises
    // the cycle after an accepting state is entered.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
            S_CSUM_HI, S_CSUM_LO: in_ready = 1'b1;
            S_WRITE:              mem_we   = 1'b1;
            S_IDLE:               busy     = 1'b0;
            S_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign word_cnt  = word_cnt_q;

    // Next-state logic. The write address advances when leaving WRITE, so
    // mem_addr always points at the word about to be written.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_cnt_d = word_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    word_cnt_d = 16'd0;
                    addr_d     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 16'd0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_rx != 16'd0 && len_rx <= MAX_LEN) begin
                        state_d = S_DATA_HI;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    wdata_d = len_rx;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                addr_d     = addr_q + 16'd2;
`ifdef LOADER_CHECKSUM_EN
                sum_d      = sum_q + wdata_q;
`endif
                if (word_cnt_q + 16'd1 != len_q) begin
                    state_d = S_DATA_HI;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM_HI;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_CSUM_LO;
                end
            end
            S_CSUM_LO: begin
                if (xfer) begin
                    csum_d  = len_rx;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (csum_q == sum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset has priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hi_q       <= 8'd0;
            len_q      <= 16'd0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 16'd0;
            word_cnt_q <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 16'd0;
            csum_q     <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_cnt_q <= word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
//
// Self-checking bench for inst_loader. A table of image descriptions (length
// field, in_valid pattern, checksum corruption, expected outcome) is applied
// in a loop, followed by randomized images and hand-written sequences for
// reset, mid-load reset, start-while-busy and reset/start collisions.
// Expected memory writes come from a simple array model: word i of the image
// must land at BASE + 2*i, and the checksum is the plain 16-bit sum.
// ---------------------------------------------------------------------------
module tb_inst_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam int          MAXW = 256;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_cnt;

    inst_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_q[$];
    logic [15:0] img_q[$];

    typedef struct {
        logic [15:0] n;
        bit          toggle;
        bit          bad;
        bit          exp_done_nocs;
        bit          exp_done_cs;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected response", name);
    endtask

    // Captures every memory write; a write cycle must never accept a byte.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            checkOutput("in_ready_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and holds it until the loader takes it.
    task automatic sendByte(input logic [7:0] b, input bit gap);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (in_ready) begin
            @(negedge clk);
        end else begin
            timeoutFail("byte_accept");
        end
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic sendWord(input logic [15:0] w, input bit gap);
        sendByte(w[15:8], gap);
        sendByte(w[7:0], gap);
    endtask

    task automatic waitResult();
        int k;
        k = 0;
        while (!(done || error) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!(done || error)) timeoutFail("wait_done_or_error");
    endtask

    function automatic logic [15:0] modelSum();
        logic [15:0] s;
        s = 16'd0;
        foreach (img_q[i]) s = s + img_q[i];
        return s;
    endfunction

    // Sends a whole image (length n, words from img_q) and waits for the end.
    task automatic applyStimulus(input logic [15:0] n, input bit toggle, input bit bad);
        logic [15:0] cs;
        wr_q.delete();
        pulseStart();
        sendWord(n, toggle);
        if (n != 16'd0 && int'(n) <= MAXW) begin
            foreach (img_q[i]) sendWord(img_q[i], toggle);
            if (CSUM) begin
                cs = modelSum();
                if (bad) cs = cs + 16'd1;
                sendWord(cs, toggle);
            end
        end
        in_valid = 1'b0;
        waitResult();
    endtask

    task automatic checkResult(input string tag, input bit exp_done, input int exp_words);
        logic [15:0] a;
        checkOutput({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
        checkOutput({tag, "_error"},    {31'd0, error},    {31'd0, !exp_done});
        checkOutput({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        checkOutput({tag, "_busy"},     {31'd0, busy},     32'd0);
        checkOutput({tag, "_word_cnt"}, {16'd0, word_cnt}, exp_words);
        checkOutput({tag, "_nwrites"},  wr_q.size(),       exp_words);
        for (int i = 0; i < exp_words && i < wr_q.size(); i++) begin
            a = BASE + 16'(2 * i);
            checkOutput($sformatf("%s_write%0d", tag, i), wr_q[i], {a, img_q[i]});
        end
    endtask

    task automatic fillRandom(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back(16'($urandom));
    endtask

    initial begin
        int n;
        bit tg;
        bit bd;
        bit exp_ok;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{16'd1,      1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[1] = '{16'd3,      1'b1, 1'b0, 1'b1, 1'b1, 3};
        vecs[2] = '{16'd0,      1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{16'd257,    1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{16'd256,    1'b0, 1'b0, 1'b1, 1'b1, 256};
        vecs[5] = '{16'hFFFF,   1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{16'd4,      1'b0, 1'b1, 1'b1, 1'b0, 4};
        vecs[7] = '{16'd2,      1'b1, 1'b1, 1'b1, 1'b0, 2};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Reset state after an idle stretch.
        checkOutput("rst_cpu_hold",  {31'd0, cpu_hold}, 32'd1);
        checkOutput("rst_busy",      {31'd0, busy},     32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        checkOutput("rst_done",      {31'd0, done},     32'd0);
        checkOutput("rst_error",     {31'd0, error},    32'd0);
        checkOutput("rst_word_cnt",  {16'd0, word_cnt}, 32'd0);
        checkOutput("rst_mem_addr",  {16'd0, mem_addr}, {16'd0, BASE});
        checkOutput("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        checkOutput("rst_no_writes", wr_q.size(),       32'd0);

        // Reference image 00 02 12 34 AB CD (checksum BE01 when enabled).
        img_q.delete();
        img_q.push_back(16'h1234);
        img_q.push_back(16'hABCD);
        checkOutput("ref_csum_model", {16'd0, modelSum()}, 32'h0000BE01);
        applyStimulus(16'd2, 1'b0, 1'b0);
        checkResult("ref", 1'b1, 2);

        // Single word F025 with in_valid toggling and a start while busy.
        img_q.delete();
        img_q.push_back(16'hF025);
        wr_q.delete();
        pulseStart();
        sendWord(16'd1, 1'b1);
        sendByte(8'hF0, 1'b1);
        pulseStart();
        checkOutput("start_busy_ignored", {31'd0, busy}, 32'd1);
        sendByte(8'h25, 1'b1);
        if (CSUM) sendWord(16'hF025, 1'b1);
        in_valid = 1'b0;
        waitResult();
        checkResult("single", 1'b1, 1);

        // Table-driven images.
        foreach (vecs[v]) begin
            fillRandom((vecs[v].n != 16'd0 && int'(vecs[v].n) <= MAXW) ? int'(vecs[v].n) : 0);
            if (v == 6) begin
                img_q.delete();
                img_q.push_back(16'h0005);
                img_q.push_back(16'h0000);
                img_q.push_back(16'h0000);
                img_q.push_back(16'h0000);
            end
            applyStimulus(vecs[v].n, vecs[v].toggle, vecs[v].bad);
            checkResult($sformatf("vec%0d", v),
                        CSUM ? vecs[v].exp_done_cs : vecs[v].exp_done_nocs,
                        vecs[v].exp_words);
        end

        // Randomized images against the model.
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 12);
            tg = 1'($urandom_range(0, 1));
            bd = 1'($urandom_range(0, 1));
            exp_ok = !(CSUM && bd);
            fillRandom(n);
            applyStimulus(16'(n), tg, bd);
            checkResult($sformatf("rand%0d", r), exp_ok, n);
        end

        // Reset after the first data HI byte, then a full reload.
        wr_q.delete();
        pulseStart();
        sendWord(16'd2, 1'b0);
        sendByte(8'h12, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_busy",     {31'd0, busy},     32'd0);
        checkOutput("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        fillRandom(2);
        applyStimulus(16'd2, 1'b0, 1'b0);
        checkResult("reload", 1'b1, 2);

        // Reset and start together from DONE: reset must win.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rststart_busy",     {31'd0, busy},     32'd0);
        checkOutput("rststart_done",     {31'd0, done},     32'd0);
        checkOutput("rststart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        checkOutput("rststart_in_ready", {31'd0, in_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
